// File: rtl/score_pkg.sv
// Shared constants and types for the score display: segment patterns,
// conversion FSM states and the BCD digit type.
package score_pkg;

  // Active-low segments, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/score_display_bcd_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank
// override; non-decimal codes also blank.
module seg7_decoder
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_bcd.sv
// Sequential double-dabble binary-to-BCD score converter driving DIGITS
// 7-segment outputs. Define SCORE_LZB_EN for leading-zero blanking.
module score_display_bcd
  import score_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      score,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int MAX_VAL = 10**DIGITS - 1;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  // Only selected when MAX_VAL is below 2**BIN_W, so the cast never loses bits
  localparam logic [BIN_W-1:0] MAX_OP = BIN_W'(MAX_VAL);

  state_t                state_reg;
  logic [BIN_W-1:0]      operand_reg;
  logic [4*DIGITS-1:0]   work_reg;
  logic [4*DIGITS-1:0]   adj;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  ovf_pend_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  ovf_reg;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic                  over_max;
  logic [DIGITS-1:0]     blank;

  assign over_max = 32'(score) > 32'(MAX_VAL);

  // Add-3 correction on every working digit before the shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                              work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      operand_reg  <= '0;
      work_reg     <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      bcd_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (load) begin
            operand_reg  <= over_max ? MAX_OP : score;
            ovf_pend_reg <= over_max;
            work_reg     <= '0;
            cnt_reg      <= CNT_W'(BIN_W);
            busy_reg     <= 1'b1;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          {work_reg, operand_reg} <= {adj[4*DIGITS-2:0], operand_reg, 1'b0};
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            busy_reg  <= 1'b0;
            state_reg <= UPDATE;
          end
        end
        UPDATE: begin
          bcd_reg   <= work_reg;
          ovf_reg   <= ovf_pend_reg;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SCORE_LZB_EN
  // zero_run[i]: digit i and every digit above it are zero
  logic [DIGITS-1:0] zero_run;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
      if (gi == DIGITS - 1) begin : g_top
        assign zero_run[gi] = (bcd_reg[4*gi +: 4] == 4'd0);
      end else begin : g_low
        assign zero_run[gi] = (bcd_reg[4*gi +: 4] == 4'd0) & zero_run[gi+1];
      end
      if (gi == 0) begin : g_d0
        assign blank[gi] = 1'b0;
      end else begin : g_dn
        assign blank[gi] = zero_run[gi];
      end
    end
  endgenerate
`else
  assign blank = '0;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      seg7_decoder u_dec (
        .digit (bcd_reg[4*gi +: 4]),
        .blank (blank[gi]),
        .seg   (hex[7*gi +: 7])
      );
    end
  endgenerate

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = ovf_reg;
  assign bcd      = bcd_reg;

endmodule

// File: tb/tb_score_display_bcd.sv
// Directed self-checking bench for score_display_bcd (default parameters);
// expected hex values follow SCORE_LZB_EN when defined.
module tb_score_display_bcd;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] score;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd;
  logic [27:0] hex;

  int vectors = 0;
  int miscompares = 0;

  score_display_bcd #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd      (bcd),
    .hex      (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion; lat = edges from accept to done (0 on timeout),
  // bcnt = number of post-edge samples with busy high before done.
  task automatic convert(input logic [13:0] s, input bit hold, output int lat, output int bcnt);
    @(negedge clk);
    score = s;
    load  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) load = 1'b0;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  logic [13:0] tv_score [4] = '{14'd9999, 14'd10000, 14'd16383, 14'd0};
  logic [15:0] tv_bcd   [4] = '{16'h9999, 16'h9999, 16'h9999, 16'h0000};
  logic        tv_ovf   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    logic [27:0] exp_hex;

    reset = 1'b1;
    load  = 1'b0;
    score = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
`ifdef SCORE_LZB_EN
    exp_hex = {SB, SB, SB, S0};
`else
    exp_hex = {S0, S0, S0, S0};
`endif
    check("rst_hex", 32'(hex), 32'(exp_hex));
    @(negedge clk);
    reset = 1'b0;

    // Basic conversion
    convert(14'd1234, 1'b0, lat, bcnt);
    check("1234_lat", 32'(lat), 32'd15);
    check("1234_busy_cycles", 32'(bcnt), 32'd14);
    check("1234_bcd", 32'(bcd), 32'h1234);
    check("1234_hex", 32'(hex), 32'({S1, S2, S3, S4}));
    check("1234_ovf", 32'(overflow), 32'd0);
    check("1234_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("1234_done_pulse", 32'(done), 32'd0);
    check("1234_bcd_hold", 32'(bcd), 32'h1234);

    // Saturation boundaries
    for (int i = 0; i < 4; i++) begin
      convert(tv_score[i], 1'b0, lat, bcnt);
      $display("vec score=%0d bcd=%h ovf=%0b lat=%0d", tv_score[i], bcd, overflow, lat);
      check("bnd_lat", 32'(lat), 32'd15);
      check("bnd_bcd", 32'(bcd), 32'(tv_bcd[i]));
      check("bnd_ovf", 32'(overflow), 32'(tv_ovf[i]));
    end
    check("9999_hex_prev", 32'(bcd), 32'h0);

    // Busy lockout: second load at k+5 is dropped
    @(negedge clk);
    score = 14'd42;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      load = (n == 5);
      if (n == 5) score = 14'd777;
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("lock_done_count", 32'(dcnt), 32'd1);
    check("lock_bcd", 32'(bcd), 32'h0042);
    check("lock_busy", 32'(busy), 32'd0);

    // load held through the done cycle restarts at the following edge
    convert(14'd777, 1'b1, lat, bcnt);
    check("hold_lat1", 32'(lat), 32'd15);
    check("hold_bcd1", 32'(bcd), 32'h0777);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check("hold_restart_busy", 32'(busy), 32'd1);
        load = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check("hold_lat2", 32'(lat), 32'd16);
    check("hold_bcd2", 32'(bcd), 32'h0777);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    score = 14'd5555;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    convert(14'd321, 1'b0, lat, bcnt);
    check("321_lat", 32'(lat), 32'd15);
    check("321_bcd", 32'(bcd), 32'h0321);

    // Leading-zero display
    convert(14'd7, 1'b0, lat, bcnt);
`ifdef SCORE_LZB_EN
    exp_hex = {SB, SB, SB, S7};
`else
    exp_hex = {S0, S0, S0, S7};
`endif
    check("7_bcd", 32'(bcd), 32'h0007);
    check("7_hex", 32'(hex), 32'(exp_hex));
    convert(14'd1005, 1'b0, lat, bcnt);
    check("1005_bcd", 32'(bcd), 32'h1005);
    check("1005_hex", 32'(hex), 32'({S1, S0, S0, S5}));
    convert(14'd9999, 1'b0, lat, bcnt);
    check("9999_hex", 32'(hex), 32'({S9, S9, S9, S9}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
